// File: rtl/hazard3_ifetch_tcm_responder_pkg.sv
`default_nettype none
// ============================================================================
// hazard3_ifetch_tcm_responder_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the instruction-fetch TCM responder: FSM state
// encoding, counter width and the TCM window-size helper.
// Revision: 1.0 - initial release
// ============================================================================
package hazard3_ifetch_tcm_responder_pkg;

  localparam int XLEN      = 32;
  localparam int c_wait_w  = 4;
  localparam int c_state_w = 3;

  localparam logic [c_state_w-1:0] c_idle = 3'd0;
  localparam logic [c_state_w-1:0] c_wait = 3'd1;
  localparam logic [c_state_w-1:0] c_last = 3'd2;
  localparam logic [c_state_w-1:0] c_err1 = 3'd3;
  localparam logic [c_state_w-1:0] c_err2 = 3'd4;

  // Window size in bytes; one extra bit so a window covering the whole
  // 32-bit space is still representable.
  function automatic logic [XLEN:0] window_bytes(input int depth_log2);
    logic [XLEN:0] one;
    one = {{XLEN{1'b0}}, 1'b1};
    window_bytes = one << (depth_log2 + 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard3_tcm_addr_decode.sv
`default_nettype none
// ============================================================================
// hazard3_tcm_addr_decode
// ----------------------------------------------------------------------------
// Combinational TCM window and privilege check.
// Ports:
//   addr  in  32  byte address of the access
//   priv  in  1   1 = M-mode, 0 = U-mode
//   err   out 1   access is outside the window or hits the protected region
// Revision: 1.0 - initial release
// ============================================================================
module hazard3_tcm_addr_decode
  import hazard3_ifetch_tcm_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          DEPTH_LOG2 = 11,
  parameter logic [31:0] MPROT_TOP  = 32'h0000_0400
) (
  input  logic [XLEN-1:0] addr,
  input  logic            priv,
  output logic            err
);

  localparam logic [XLEN:0] c_window = window_bytes(DEPTH_LOG2);

  logic [XLEN-1:0] w_offset;
  logic            w_out_of_range;
  logic            w_prot_fault;

  // Addresses below the base wrap to a huge offset, so one unsigned compare
  // covers both ends of the window.
  assign w_offset       = addr - BASE_ADDR;
  assign w_out_of_range = {1'b0, w_offset} >= c_window;
  assign w_prot_fault   = !priv && (w_offset < MPROT_TOP);
  assign err            = w_out_of_range || w_prot_fault;

endmodule
`default_nettype wire

// File: rtl/hazard3_ifetch_tcm_responder.sv
`default_nettype none
// ============================================================================
// hazard3_ifetch_tcm_responder
// ----------------------------------------------------------------------------
// Instruction-fetch responder backed by a single-port synchronous SRAM.
// Pipelined address/data phases, per-fetch wait states, two-cycle error
// response for out-of-window or U-mode-protected fetches.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mem_size            1=word 0=halfword (whole word always returned)
//   mem_addr/mem_priv   fetch address and privilege
//   mem_addr_vld/rdy    address-phase handshake
//   mem_data/err/vld    data-phase response
//   wait_cycles         extra data-phase cycles, sampled at acceptance
//   sram_en/addr/rdata  SRAM read port (rdata valid the cycle after en)
// Revision: 1.0 - initial release
// ============================================================================
module hazard3_ifetch_tcm_responder
  import hazard3_ifetch_tcm_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          DEPTH_LOG2 = 11,
  parameter logic [31:0] MPROT_TOP  = 32'h0000_0400
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_size,
  input  logic [31:0]           mem_addr,
  input  logic                  mem_priv,
  input  logic                  mem_addr_vld,
  output logic                  mem_addr_rdy,
  output logic [31:0]           mem_data,
  output logic                  mem_data_err,
  output logic                  mem_data_vld,
  input  logic [3:0]            wait_cycles,
  output logic                  sram_en,
  output logic [DEPTH_LOG2-1:0] sram_addr,
  input  logic [31:0]           sram_rdata
);

  logic [c_state_w-1:0]  r_state;
  logic [c_state_w-1:0]  w_state_nxt;
  logic [c_state_w-1:0]  w_accept_target;
  logic [c_wait_w-1:0]   r_count;
  logic [DEPTH_LOG2-1:0] r_addr;
  logic                  r_err;
  logic                  w_dec_err;
  logic                  w_accept;
  logic                  w_issue_now;
  logic                  w_issue_late;

  hazard3_tcm_addr_decode #(
    .BASE_ADDR  (BASE_ADDR),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .MPROT_TOP  (MPROT_TOP)
  ) u_decode (
    .addr (mem_addr),
    .priv (mem_priv),
    .err  (w_dec_err)
  );

  assign w_accept = mem_addr_vld && mem_addr_rdy;

  // Where a freshly accepted request goes: waits take priority, then the
  // error path, otherwise data lands in the very next cycle.
  assign w_accept_target = (wait_cycles != '0) ? c_wait :
                           w_dec_err           ? c_err1 : c_last;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle, c_last, c_err2: w_state_nxt = w_accept ? w_accept_target : c_idle;
      c_wait: begin
        if (r_count == 4'd1) begin
          w_state_nxt = r_err ? c_err1 : c_last;
        end
      end
      c_err1:  w_state_nxt = c_err2;
      default: w_state_nxt = c_idle;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    mem_addr_rdy = 1'b0;
    mem_data_vld = 1'b0;
    mem_data_err = 1'b0;
    mem_data     = '0;
    case (r_state)
      c_idle: mem_addr_rdy = 1'b1;
      c_last: begin
        mem_addr_rdy = 1'b1;
        mem_data_vld = 1'b1;
        mem_data     = sram_rdata;
      end
      c_err1: mem_data_err = 1'b1;
      c_err2: begin
        mem_addr_rdy = 1'b1;
        mem_data_vld = 1'b1;
        mem_data_err = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_addr  <= mem_addr[DEPTH_LOG2+1:2];
      r_err   <= w_dec_err;
      r_count <= wait_cycles;
    end else if (r_state == c_wait) begin
      r_count <= r_count - 4'd1;
    end
  end

  // The read is launched exactly one cycle before LAST so rdata arrives in
  // LAST without a holding register. Zero-wait fetches must read straight
  // from the incoming address; delayed fetches use the latched copy.
  assign w_issue_now  = w_accept && (wait_cycles == '0) && !w_dec_err;
  assign w_issue_late = (r_state == c_wait) && (r_count == 4'd1) && !r_err;
  assign sram_en      = w_issue_now || w_issue_late;
  assign sram_addr    = w_issue_now ? mem_addr[DEPTH_LOG2+1:2] : r_addr;

  // ---------------------------------------------------------------- properties
  logic r_outstanding;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= 1'b0;
    end else if (w_accept) begin
      r_outstanding <= 1'b1;
    end else if (mem_data_vld) begin
      r_outstanding <= 1'b0;
    end
  end

  a_vld_has_request: assert property (
    @(posedge clk) disable iff (!rst_n) mem_data_vld |-> r_outstanding);

  a_single_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) w_accept |-> (!r_outstanding || mem_data_vld));

  a_request_known: assert property (
    @(posedge clk) disable iff (!rst_n)
    mem_addr_vld |-> !$isunknown({mem_size, mem_addr, mem_priv, wait_cycles}));

endmodule
`default_nettype wire

// File: tb/tb_hazard3_ifetch_tcm_responder.sv
`default_nettype none
// ============================================================================
// tb_hazard3_ifetch_tcm_responder
// ----------------------------------------------------------------------------
// Self-checking bench: expected responses are queued when a fetch is
// accepted and compared (data, error, latency) when mem_data_vld appears.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hazard3_ifetch_tcm_responder;

  localparam int DEPTH_LOG2 = 11;

  logic                  clk;
  logic                  rst_n;
  logic                  mem_size;
  logic [31:0]           mem_addr;
  logic                  mem_priv;
  logic                  mem_addr_vld;
  logic                  mem_addr_rdy;
  logic [31:0]           mem_data;
  logic                  mem_data_err;
  logic                  mem_data_vld;
  logic [3:0]            wait_cycles;
  logic                  sram_en;
  logic [DEPTH_LOG2-1:0] sram_addr;
  logic [31:0]           sram_rdata;

  hazard3_ifetch_tcm_responder #(
    .BASE_ADDR  (32'h0000_0000),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .MPROT_TOP  (32'h0000_0400)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_priv     (mem_priv),
    .mem_addr_vld (mem_addr_vld),
    .mem_addr_rdy (mem_addr_rdy),
    .mem_data     (mem_data),
    .mem_data_err (mem_data_err),
    .mem_data_vld (mem_data_vld),
    .wait_cycles  (wait_cycles),
    .sram_en      (sram_en),
    .sram_addr    (sram_addr),
    .sram_rdata   (sram_rdata)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] mem [2**DEPTH_LOG2];
  int          checks;
  int          errors;
  int          cyc;
  int          en_count;
  int          last_en_cyc;
  int          acc;
  int          st;
  int          en0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: registered read, holds value when not enabled
  always @(posedge clk) if (sram_en) sram_rdata <= mem[sram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a, input logic p);
    return (a >= 32'h0000_2000) || (!p && (a < 32'h0000_0400));
  endfunction

  // Response monitor
  always @(negedge clk) begin
    if (sram_en) begin
      en_count++;
      last_en_cyc = cyc;
    end
    if (mem_data_vld) begin
      if (sb.size() == 0) begin
        check("spurious_vld", 32'(mem_data_vld), 32'd0);
      end else begin
        e = sb.pop_front();
        check("resp_data", mem_data, e.data);
        check("resp_err", 32'(mem_data_err), 32'(e.err));
        check("resp_latency", 32'(cyc), 32'(e.cyc));
      end
    end else begin
      check("data_idle", mem_data, 32'd0);
    end
  end

  // Drive one fetch; returns the acceptance cycle and number of stall cycles.
  // Called just after a rising edge, returns just after the accepting edge.
  task automatic fetch(input logic [31:0] a, input logic p, input logic [3:0] w,
                       input logic sz, output int acc_cyc, output int stalls);
    exp_t x;
    logic er;
    mem_addr     = a;
    mem_priv     = p;
    wait_cycles  = w;
    mem_size     = sz;
    mem_addr_vld = 1'b1;
    stalls       = 0;
    acc_cyc      = -1;
    @(negedge clk);
    while (!mem_addr_rdy && stalls < 40) begin
      @(negedge clk);
      stalls++;
    end
    if (!mem_addr_rdy) begin
      check("accept_timeout", 32'(mem_addr_rdy), 32'd1);
    end else begin
      er      = model_err(a, p);
      acc_cyc = cyc;
      x.err   = er;
      x.data  = er ? 32'd0 : (32'hA500_0000 | {21'd0, a[12:2]});
      x.cyc   = cyc + 1 + int'(w) + (er ? 1 : 0);
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    mem_addr_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; en_count = 0; last_en_cyc = -1;
    acc = 0; st = 0; en0 = 0;
    sram_rdata = 32'd0;
    for (int i = 0; i < 2**DEPTH_LOG2; i++) mem[i] = 32'hA500_0000 | i;
    rst_n = 1'b0; mem_size = 1'b1; mem_addr = 32'd0; mem_priv = 1'b1;
    mem_addr_vld = 1'b0; wait_cycles = 4'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_vld", 32'(mem_data_vld), 32'd0);
    check("rst_err", 32'(mem_data_err), 32'd0);
    check("rst_data", mem_data, 32'd0);
    check("rst_sram_en", 32'(sram_en), 32'd0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_rdy", 32'(mem_addr_rdy), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back zero-wait fetches
    en0 = en_count;
    fetch(32'h0, 1'b1, 4'd0, 1'b1, acc, st); check("b2b_stall0", 32'(st), 32'd0);
    fetch(32'h4, 1'b1, 4'd0, 1'b1, acc, st); check("b2b_stall1", 32'(st), 32'd0);
    fetch(32'h8, 1'b1, 4'd0, 1'b1, acc, st); check("b2b_stall2", 32'(st), 32'd0);
    drain();
    check("b2b_en_count", 32'(en_count - en0), 32'd3);

    // Three wait states
    en0 = en_count;
    fetch(32'h10, 1'b1, 4'd3, 1'b1, acc, st);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("w3_rdy_low", 32'(mem_addr_rdy), 32'd0);
    end
    @(negedge clk);
    check("w3_rdy_last", 32'(mem_addr_rdy), 32'd1);
    drain();
    check("w3_en_count", 32'(en_count - en0), 32'd1);
    check("w3_en_cycle", 32'(last_en_cyc), 32'(acc + 3));

    // Out-of-window fetch, zero waits
    en0 = en_count;
    fetch(32'h2000, 1'b1, 4'd0, 1'b1, acc, st);
    @(negedge clk);
    check("err1_rdy", 32'(mem_addr_rdy), 32'd0);
    check("err1_vld", 32'(mem_data_vld), 32'd0);
    check("err1_err", 32'(mem_data_err), 32'd1);
    drain();
    // Error with waits, then wrapped-below-base style huge address
    fetch(32'h2000, 1'b1, 4'd2, 1'b1, acc, st);
    fetch(32'hFFFF_FFFC, 1'b1, 4'd0, 1'b1, acc, st);
    drain();
    check("err_no_en", 32'(en_count - en0), 32'd0);

    // Privilege boundary and window top
    fetch(32'h100, 1'b0, 4'd0, 1'b1, acc, st);
    fetch(32'h100, 1'b1, 4'd0, 1'b1, acc, st);
    fetch(32'h3FC, 1'b0, 4'd0, 1'b1, acc, st);
    fetch(32'h400, 1'b0, 4'd0, 1'b1, acc, st);
    fetch(32'h1FFC, 1'b1, 4'd1, 1'b1, acc, st);
    fetch(32'h6, 1'b1, 4'd0, 1'b0, acc, st);
    drain();

    // wait_cycles changed while the first fetch is in flight
    fetch(32'h20, 1'b1, 4'd2, 1'b1, acc, st);
    fetch(32'h24, 1'b1, 4'd0, 1'b1, acc, st);
    check("midchange_stall", 32'(st), 32'd2);
    drain();

    // Asynchronous reset during WAIT discards the fetch
    fetch(32'h40, 1'b1, 4'd3, 1'b1, acc, st);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", 32'(mem_addr_rdy), 32'd1);
    check("post_rst_vld", 32'(mem_data_vld), 32'd0);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    fetch(32'h44, 1'b1, 4'd0, 1'b1, acc, st);
    check("post_rst_stall", 32'(st), 32'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
